wash_program_timer: RTL

- Sequencing controller for the washer FSM. Issues the start request and holds it until the door is locked.
- Times the wash/rinse and spin phases according to a selected wash program, and drives the washer's machinecycle_timeout and spin_timeout_check inputs.
- Sits beside the washer FSM. Its phase inputs come from the washer's motor and spin indications, and it also reports busy, remaining time and error status.

---
 rtl/wash_program_timer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wash_program_timer.sv
// Program timer beside the washer FSM: start handshake, wash/rinse and spin phase timing.
// Build macro TIMER_PAUSE_EN makes the pause input freeze phase timing.
module wash_program_timer #(
    parameter int CNT_W       = 16,
    parameter int PRESCALE    = 1000,
    parameter int WASH_NORMAL = 1200,
    parameter int WASH_QUICK  = 600,
    parameter int WASH_HEAVY  = 2400,
    parameter int SPIN_TICKS  = 300,
    parameter int ARM_TIMEOUT = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic [1:0]       program_sel,
    input  logic             abort,
    input  logic             pause,
    input  logic             doorlock_check,
    input  logic             wash_active,
    input  logic             spin_active,
    input  logic             done,
    output logic             startmachine,
    output logic             machinecycle_timeout,
    output logic             spin_timeout_check,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [2:0]       wash_count,
    output logic             error,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_WASH = 3'd3,
        S_SPIN = 3'd4
    } state_t;

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0]    P_LAST   = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    P_ONE    = PW'(1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'((ARM_TIMEOUT > 0) ? ARM_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_TICKS);

    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] arm_cnt_q;
    logic [1:0]       prog_q;
    logic [2:0]       wash_count_q;
    logic             error_q;
    logic             startmachine_q;
    logic             mct_q;
    logic             stc_q;
    logic             wash_prev_q;
    logic             spin_prev_q;

    logic             run;
    logic             tick;
    logic [PW-1:0]    presc_d;
    logic [CNT_W-1:0] remaining_d;
    logic [CNT_W-1:0] wash_dur;

`ifdef TIMER_PAUSE_EN
    assign run = !pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign run = 1'b1;
`endif

    // Frozen prescaler means no tick, so remaining also holds while paused.
    assign tick        = run && (presc_q == P_LAST);
    assign presc_d     = !run ? presc_q : (tick ? '0 : presc_q + P_ONE);
    assign remaining_d = (tick && remaining_q != '0) ? remaining_q - C_ONE : remaining_q;

    always_comb begin
        wash_dur = CNT_W'(WASH_NORMAL);
        case (prog_q)
            2'b01:   wash_dur = CNT_W'(WASH_QUICK);
            2'b10:   wash_dur = CNT_W'(WASH_HEAVY);
            default: wash_dur = CNT_W'(WASH_NORMAL);
        endcase
    end

    // Handshake: startmachine is a request raised on entry to ARM and held until
    // doorlock_check is sampled high; it drops the cycle after that acknowledge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            presc_q        <= '0;
            remaining_q    <= '0;
            arm_cnt_q      <= '0;
            prog_q         <= 2'b00;
            wash_count_q   <= 3'd0;
            error_q        <= 1'b0;
            startmachine_q <= 1'b0;
            mct_q          <= 1'b0;
            stc_q          <= 1'b0;
            wash_prev_q    <= 1'b0;
            spin_prev_q    <= 1'b0;
        end else begin
            wash_prev_q <= wash_active;
            spin_prev_q <= spin_active;
            if (abort || (state_q != S_IDLE && wash_active && spin_active)) begin
                state_q        <= S_IDLE;
                presc_q        <= '0;
                remaining_q    <= '0;
                arm_cnt_q      <= '0;
                wash_count_q   <= 3'd0;
                startmachine_q <= 1'b0;
                mct_q          <= 1'b0;
                stc_q          <= 1'b0;
                if (!abort) error_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_req && program_sel == 2'b11) begin
                            error_q <= 1'b1;
                        end else if (start_req) begin
                            prog_q         <= program_sel;
                            wash_count_q   <= 3'd0;
                            error_q        <= 1'b0;
                            presc_q        <= '0;
                            arm_cnt_q      <= '0;
                            startmachine_q <= 1'b1;
                            state_q        <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (doorlock_check) begin
                            startmachine_q <= 1'b0;
                            state_q        <= S_WAIT;
                        end else if (tick && arm_cnt_q == ARM_LAST) begin
                            startmachine_q <= 1'b0;
                            error_q        <= 1'b1;
                            state_q        <= S_IDLE;
                        end else begin
                            presc_q <= presc_d;
                            if (tick) arm_cnt_q <= arm_cnt_q + C_ONE;
                        end
                    end
                    S_WAIT: begin
                        if (wash_active && !wash_prev_q) begin
                            presc_q     <= '0;
                            remaining_q <= wash_dur;
                            mct_q       <= (wash_dur == '0);
                            state_q     <= S_WASH;
                        end else if (spin_active && !spin_prev_q) begin
                            presc_q     <= '0;
                            remaining_q <= SPIN_LD;
                            stc_q       <= (SPIN_LD == '0);
                            state_q     <= S_SPIN;
                        end else if (done) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_WASH: begin
                        if (!wash_active) begin
                            // Only an expired phase counts as a completed wash.
                            if (remaining_q == '0 && wash_count_q != 3'd7)
                                wash_count_q <= wash_count_q + 3'd1;
                            remaining_q <= '0;
                            mct_q       <= 1'b0;
                            state_q     <= S_WAIT;
                        end else begin
                            presc_q     <= presc_d;
                            remaining_q <= remaining_d;
                            mct_q       <= (remaining_d == '0);
                        end
                    end
                    S_SPIN: begin
                        if (!spin_active) begin
                            remaining_q <= '0;
                            stc_q       <= 1'b0;
                            state_q     <= S_WAIT;
                        end else begin
                            presc_q     <= presc_d;
                            remaining_q <= remaining_d;
                            stc_q       <= (remaining_d == '0);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign startmachine         = startmachine_q;
    assign machinecycle_timeout = mct_q;
    assign spin_timeout_check   = stc_q;
    assign busy                 = (state_q != S_IDLE);
    assign remaining            = remaining_q;
    assign wash_count           = wash_count_q;
    assign error                = error_q;
    assign dbg_state_o          = state_q;

endmodule
